// File: rtl/axi4_pkg.sv
// Shared AXI4 constants: response codes and write-responder FSM encodings.
package axi4_pkg;

  // BRESP / RRESP encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write-responder state encodings
  localparam logic [1:0] IDLE_ST = 2'd0;
  localparam logic [1:0] DATA_ST = 2'd1;
  localparam logic [1:0] RESP_ST = 2'd2;

endpackage

// File: rtl/axi4_wr_slave_fb.sv
// AXI4 write responder feeding a frame-buffer SRAM write port.
// One AW, one burst of W beats written at incrementing word addresses with
// zero latency, then one B response. At most one transaction outstanding.
module axi4_wr_slave_fb
  import axi4_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                MST_ID_W     = 5,
  parameter int                TRANS_RESP_W = 2,
  parameter int                TX_PER_TXN   = 19200,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
  parameter int                MEM_ADDR_W   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MST_ID_W-1:0]     m_awid_i,
  input  logic [ADDR_W-1:0]       m_awaddr_i,
  input  logic                    m_awvalid_i,
  output logic                    m_awready_o,
  input  logic [DATA_W-1:0]       m_wdata_i,
  input  logic                    m_wlast_i,
  input  logic                    m_wvalid_i,
  output logic                    m_wready_o,
  output logic [MST_ID_W-1:0]     m_bid_o,
  output logic [TRANS_RESP_W-1:0] m_bresp_o,
  output logic                    m_bvalid_o,
  input  logic                    m_bready_i,
  output logic                    mem_we_o,
  output logic [MEM_ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]       mem_data_o,
  input  logic                    mem_rdy_i
);

  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);
  localparam int CNT_W          = $clog2(TX_PER_TXN + 1);

  localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(1) << MEM_ADDR_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ADDR_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(TX_PER_TXN - 1);

  logic [1:0]            state_q, state_d;
  logic [MST_ID_W-1:0]   id_q, id_d;
  logic [MEM_ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  addr_err_q, addr_err_d;
  logic                  len_err_q, len_err_d;

  logic [ADDR_W-1:0] byte_off;
  logic [ADDR_W-1:0] word_off;
  logic              aw_err;
  logic              aw_hs, w_hs, b_hs;
  logic              beat_is_last;

  // Decode the AW address into a word offset and classify it
  assign byte_off = m_awaddr_i - BASE_ADDR;
  assign word_off = byte_off >> WORD_SHIFT;
  assign aw_err   = (m_awaddr_i < BASE_ADDR)
                  | (|(m_awaddr_i & ALIGN_MASK))
                  | (word_off >= DEPTH_WORDS);

  // Handshakes; W ready follows SRAM readiness so backpressure is immediate
  assign m_awready_o  = (state_q == IDLE_ST);
  assign m_wready_o   = (state_q == DATA_ST) & mem_rdy_i;
  assign m_bvalid_o   = (state_q == RESP_ST);
  assign aw_hs        = m_awvalid_i & m_awready_o;
  assign w_hs         = m_wvalid_i & m_wready_o;
  assign b_hs         = m_bvalid_o & m_bready_i;
  assign beat_is_last = (cnt_q == LAST_BEAT);

  // Zero-latency SRAM write; beats after an address error are swallowed
  assign mem_we_o   = w_hs & ~addr_err_q;
  assign mem_addr_o = ptr_q;
  assign mem_data_o = m_wdata_i;

  // B channel: ID is held from AW, response code resolved by priority
  assign m_bid_o = id_q;
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    m_bresp_o = TRANS_RESP_W'(RESP_OKAY);
    if (state_q == RESP_ST) begin
      if (addr_err_q)     m_bresp_o = TRANS_RESP_W'(RESP_DECERR);
      else if (len_err_q) m_bresp_o = TRANS_RESP_W'(RESP_SLVERR);
    end
  end

  // Next-state logic for the transaction FSM and its datapath registers
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    addr_err_d = addr_err_q;
    len_err_d  = len_err_q;
    case (state_q)
      IDLE_ST: begin
        if (aw_hs) begin
          id_d       = m_awid_i;
          ptr_d      = word_off[MEM_ADDR_W-1:0];
          addr_err_d = aw_err;
          len_err_d  = 1'b0;
          cnt_d      = '0;
          state_d    = DATA_ST;
        end
      end
      DATA_ST: begin
        if (w_hs) begin
          ptr_d = ptr_q + MEM_ADDR_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          // Stepping off the top word: no wrap, the rest of the burst is dropped
          if (&ptr_q) addr_err_d = 1'b1;
          if (m_wlast_i | beat_is_last) begin
            len_err_d = m_wlast_i ^ beat_is_last;
            state_d   = RESP_ST;
          end
        end
      end
      RESP_ST: begin
        if (b_hs) begin
          cnt_d      = '0;
          addr_err_d = 1'b0;
          len_err_d  = 1'b0;
          state_d    = IDLE_ST;
        end
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // State registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE_ST;
      id_q       <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule

// File: tb/tb_axi4_wr_slave_fb.sv
// Directed bench for axi4_wr_slave_fb with TX_PER_TXN=4, BASE_ADDR=0x1000,
// MEM_ADDR_W=4 (16-word frame buffer).
module tb_axi4_wr_slave_fb;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int ID_W       = 5;
  localparam int RESP_W     = 2;
  localparam int MEM_ADDR_W = 4;
  localparam int BUDGET     = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   m_awid_i;
  logic [ADDR_W-1:0] m_awaddr_i;
  logic              m_awvalid_i;
  logic              m_awready_o;
  logic [DATA_W-1:0] m_wdata_i;
  logic              m_wlast_i;
  logic              m_wvalid_i;
  logic              m_wready_o;
  logic [ID_W-1:0]   m_bid_o;
  logic [RESP_W-1:0] m_bresp_o;
  logic              m_bvalid_o;
  logic              m_bready_i;
  logic              mem_we_o;
  logic [MEM_ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_rdy_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Log of every SRAM write strobe seen at a clock edge
  logic [MEM_ADDR_W-1:0] log_addr [0:127];
  logic [DATA_W-1:0]     log_data [0:127];
  int                    wr_total = 0;

  axi4_wr_slave_fb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MST_ID_W(ID_W), .TRANS_RESP_W(RESP_W),
    .TX_PER_TXN(4), .BASE_ADDR(32'h1000), .MEM_ADDR_W(MEM_ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .m_awid_i(m_awid_i), .m_awaddr_i(m_awaddr_i), .m_awvalid_i(m_awvalid_i),
    .m_awready_o(m_awready_o),
    .m_wdata_i(m_wdata_i), .m_wlast_i(m_wlast_i), .m_wvalid_i(m_wvalid_i),
    .m_wready_o(m_wready_o),
    .m_bid_o(m_bid_o), .m_bresp_o(m_bresp_o), .m_bvalid_o(m_bvalid_o),
    .m_bready_i(m_bready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_rdy_i(mem_rdy_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we_o && wr_total < 128) begin
      log_addr[wr_total] = mem_addr_o;
      log_data[wr_total] = mem_data_o;
      wr_total = wr_total + 1;
    end
  end

  // Present one AW and wait (bounded) for it to be taken
  task automatic do_aw(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id);
    bit done = 0;
    m_awaddr_i = addr; m_awid_i = id; m_awvalid_i = 1'b1;
    for (int c = 0; c < BUDGET && !done; c++) begin
      @(negedge clk);
      if (m_awready_o === 1'b1) done = 1;
      @(posedge clk); #1;
    end
    m_awvalid_i = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL aw_accept: awready never seen, required 1 within %0d cycles", BUDGET);
    end
  endtask

  // Send n beats; wlast raised on beat number wlast_beat (1-based, 0 = never)
  task automatic send_burst(input int n, input int wlast_beat, input logic [DATA_W-1:0] dbase);
    for (int i = 0; i < n; i++) begin
      bit done = 0;
      m_wvalid_i = 1'b1;
      m_wdata_i  = dbase + DATA_W'(i);
      m_wlast_i  = (i + 1 == wlast_beat);
      for (int c = 0; c < BUDGET && !done; c++) begin
        @(negedge clk);
        if (m_wready_o === 1'b1) done = 1;
        @(posedge clk); #1;
      end
      n_tests++;
      if (!done) begin
        n_fail++;
        $display("FAIL w_accept: beat %0d wready never seen, required 1", i);
      end
    end
    m_wvalid_i = 1'b0;
    m_wlast_i  = 1'b0;
  endtask

  // Wait (bounded) for B, check it, complete handshake with bready=1
  task automatic wait_b(input string name, input logic [ID_W-1:0] exp_id,
                        input logic [RESP_W-1:0] exp_resp, input bit immediate);
    int waited = 0;
    bit seen = 0;
    m_bready_i = 1'b1;
    while (!seen && waited < BUDGET) begin
      @(negedge clk);
      if (m_bvalid_o === 1'b1) seen = 1;
      else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    n_tests++;
    if (!seen || (immediate && waited != 0)) begin
      n_fail++;
      $display("FAIL %s_bvalid: seen=%0d after %0d cycles, required bvalid %s",
               name, seen, waited, immediate ? "on first cycle" : "within budget");
    end
    n_tests++;
    if (m_bid_o !== exp_id || m_bresp_o !== exp_resp) begin
      n_fail++;
      $display("FAIL %s_b: bid=%h bresp=%b, required bid=%h bresp=%b",
               name, m_bid_o, m_bresp_o, exp_id, exp_resp);
    end
    @(posedge clk); #1;
  endtask

  // Compare writes logged since 'base' against count words from start_word
  task automatic check_writes(input string name, input int base, input int count,
                              input int start_word, input logic [DATA_W-1:0] dbase);
    n_tests++;
    if (wr_total - base != count) begin
      n_fail++;
      $display("FAIL %s_wr_count: got %0d writes, required %0d", name, wr_total - base, count);
    end else begin
      for (int i = 0; i < count; i++) begin
        n_tests++;
        if (log_addr[base+i] !== MEM_ADDR_W'(start_word + i) || log_data[base+i] !== dbase + DATA_W'(i)) begin
          n_fail++;
          $display("FAIL %s_wr%0d: addr=%0d data=%h, required addr=%0d data=%h", name, i,
                   log_addr[base+i], log_data[base+i], start_word + i, dbase + DATA_W'(i));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_awvalid_i = 0; m_awid_i = '0; m_awaddr_i = '0;
    m_wvalid_i = 0; m_wlast_i = 0; m_wdata_i = '0;
    m_bready_i = 1; mem_rdy_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (m_bvalid_o !== 1'b0 || m_bid_o !== '0 || m_bresp_o !== '0 ||
        m_wready_o !== 1'b0 || mem_we_o !== 1'b0 || m_awready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: bvalid=%b bid=%h bresp=%b wready=%b we=%b awready=%b, required 0 0 0 0 0 1",
               m_bvalid_o, m_bid_o, m_bresp_o, m_wready_o, mem_we_o, m_awready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int base = wr_total;
    do_aw(32'h1008, 5'h02);
    send_burst(4, 4, 32'hD000_0000);
    check_writes("nominal", base, 4, 2, 32'hD000_0000);
    wait_b("nominal", 5'h02, 2'b00, 1'b1);
  endtask

  task automatic test_backpressure();
    int base = wr_total;
    int beat = 0;
    int c = 0;
    bit bad = 0;
    do_aw(32'h1000, 5'h01);
    while (beat < 4 && c < BUDGET) begin
      bit rdy;
      rdy = !(c >= 1 && c <= 3);
      mem_rdy_i  = rdy;
      m_wvalid_i = 1'b1;
      m_wdata_i  = 32'hB000_0000 + DATA_W'(beat);
      m_wlast_i  = (beat == 3);
      @(negedge clk);
      if (m_wready_o !== rdy || mem_we_o !== rdy) begin
        bad = 1;
        $display("FAIL bp_cycle%0d: wready=%b we=%b, required both %b", c, m_wready_o, mem_we_o, rdy);
      end
      @(posedge clk); #1;
      if (rdy) beat++;
      c++;
    end
    m_wvalid_i = 0; m_wlast_i = 0; mem_rdy_i = 1;
    n_tests++;
    if (bad || beat != 4) begin
      n_fail++;
      $display("FAIL bp_flow: beats=%0d in %0d cycles, required 4 beats with correct stalls", beat, c);
    end
    check_writes("bp", base, 4, 0, 32'hB000_0000);
    wait_b("bp", 5'h01, 2'b00, 1'b1);
  endtask

  task automatic test_early_wlast();
    int base = wr_total;
    do_aw(32'h1020, 5'h03);
    send_burst(2, 2, 32'hE000_0000);
    check_writes("early", base, 2, 8, 32'hE000_0000);
    wait_b("early", 5'h03, 2'b10, 1'b1);
  endtask

  task automatic test_missing_wlast();
    int base = wr_total;
    do_aw(32'h1004, 5'h0C);
    send_burst(4, 0, 32'hF000_0000);
    check_writes("nolast", base, 4, 1, 32'hF000_0000);
    wait_b("nolast", 5'h0C, 2'b10, 1'b1);
  endtask

  task automatic test_out_of_range();
    int base = wr_total;
    do_aw(32'h1038, 5'h04);
    send_burst(4, 4, 32'hC000_0000);
    check_writes("oor_top", base, 2, 14, 32'hC000_0000);
    wait_b("oor_top", 5'h04, 2'b11, 1'b1);
    base = wr_total;
    do_aw(32'h0FFC, 5'h05);
    send_burst(4, 4, 32'hC100_0000);
    check_writes("oor_low", base, 0, 0, 32'hC100_0000);
    wait_b("oor_low", 5'h05, 2'b11, 1'b1);
  endtask

  task automatic test_b_stall();
    bit bad = 0;
    int base;
    do_aw(32'h1000, 5'h0A);
    m_bready_i = 1'b0;
    send_burst(4, 4, 32'h5000_0000);
    m_awaddr_i = 32'h1010; m_awid_i = 5'h09; m_awvalid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_bvalid_o !== 1'b1 || m_bid_o !== 5'h0A || m_bresp_o !== 2'b00 || m_awready_o !== 1'b0) begin
        bad = 1;
        $display("FAIL stall_cycle%0d: bvalid=%b bid=%h bresp=%b awready=%b, required 1 0a 00 0",
                 i, m_bvalid_o, m_bid_o, m_bresp_o, m_awready_o);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (bad) n_fail++;
    m_bready_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (m_bvalid_o !== 1'b1 || m_awready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: bvalid=%b awready=%b, required 1 0", m_bvalid_o, m_awready_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (m_bvalid_o !== 1'b0 || m_awready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_after_b: bvalid=%b awready=%b, required 0 1", m_bvalid_o, m_awready_o);
    end
    @(posedge clk); #1;
    m_awvalid_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m_awready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_aw2: awready=%b, required 0 (second AW taken)", m_awready_o);
    end
    base = wr_total;
    @(posedge clk); #1;
    send_burst(4, 4, 32'h6000_0000);
    check_writes("stall_aw2", base, 4, 4, 32'h6000_0000);
    wait_b("stall_aw2", 5'h09, 2'b00, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    bit stray_b = 0;
    int base;
    do_aw(32'h1000, 5'h11);
    send_burst(2, 0, 32'h7000_0000);
    m_wvalid_i = 1'b1; m_wdata_i = 32'h7777_7777;
    rst = 1'b1;
    base = wr_total;
    @(negedge clk);
    n_tests++;
    if (m_bvalid_o !== 1'b0 || m_bid_o !== '0 || m_bresp_o !== '0 ||
        m_wready_o !== 1'b0 || mem_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: bvalid=%b bid=%h bresp=%b wready=%b we=%b, required all 0",
               m_bvalid_o, m_bid_o, m_bresp_o, m_wready_o, mem_we_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; m_wvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_bvalid_o !== 1'b0 || mem_we_o !== 1'b0) stray_b = 1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (stray_b || wr_total != base) begin
      n_fail++;
      $display("FAIL midrst_quiet: bvalid or write seen after reset, writes=%0d, required none", wr_total - base);
    end
    do_aw(32'h1000, 5'h07);
    send_burst(4, 4, 32'h8000_0000);
    check_writes("postrst", base, 4, 0, 32'h8000_0000);
    wait_b("postrst", 5'h07, 2'b00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_wlast();
    test_missing_wlast();
    test_out_of_range();
    test_b_stall();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
